// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB bus arbiter: FSM states, master indices,
// default timing limits and the round-robin pointer advance helper.
package rib_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int M_DATA  = 0;
    localparam int M_INST  = 1;
    localparam int M_JTAG  = 2;
    localparam int M_OTHER = 3;

    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_TIMEOUT  = 255;

    // Index that follows idx when counting upward modulo n.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rib_arbiter_rr_pick.sv
// Round-robin winner search: first requester at or after the pointer,
// searching upward modulo N_MST. Purely combinational.
module rr_pick
    import rib_arbiter_pkg::*;
#(
    parameter int N_MST = 4,
    parameter int IW    = 2
) (
    input  logic [N_MST-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_MST-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    // Walk the request vector starting at the pointer; the first hit wins.
    always_comb begin
        int            w_j;
        logic [IW-1:0] w_j_idx;
        w_j     = 0;
        w_j_idx = '0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N_MST; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N_MST) begin
                w_j = w_j - N_MST;
            end else begin
                w_j = w_j;
            end
            w_j_idx = IW'(w_j);
            if (!o_valid && i_req[w_j_idx]) begin
                o_valid          = 1'b1;
                o_grant[w_j_idx] = 1'b1;
                o_idx            = w_j_idx;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: round-robin grant with lock, bounded hold under lock,
// owner timeout and a one-cycle turnover between owners.
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int N_MST    = 4,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_MST-1:0]                        req_i,
    input  logic [N_MST-1:0]                        lock_i,
    input  logic                                    done_i,
    output logic [N_MST-1:0]                        grant_o,
    output logic [((N_MST > 1) ? $clog2(N_MST) : 1)-1:0] grant_id_o,
    output logic                                    gnt_valid_o,
    output logic                                    hold_flag_o,
    output logic                                    timeout_o
);

    localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N_MST-1:0] INST_MASK = N_MST'(1) << M_INST;

    arb_state_e       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [N_MST-1:0] r_grant;
    logic             r_valid;
    logic             r_timeout;
    logic [HW-1:0]    r_hold;
    logic [TW-1:0]    r_to;

    logic [N_MST-1:0] w_pick_grant;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_owner_req;
    logic             w_owner_lock;
    logic             w_other_req;
    logic             w_hold_max;
    logic             w_to_hit;
    logic             w_release;
    logic             w_timeout;

    rr_pick #(
        .N_MST (N_MST),
        .IW    (IW)
    ) u_rr_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_owner_req  = |(req_i & r_grant);
    assign w_owner_lock = |(lock_i & r_grant);
    assign w_other_req  = |(req_i & ~r_grant);
    assign w_hold_max   = (r_hold == HW'(MAX_HOLD));
    assign w_to_hit     = (r_to == TW'(TIMEOUT - 1));

    // Decide whether the current owner gives up the bus at the next edge.
    always_comb begin
        w_release = 1'b0;
        w_timeout = 1'b0;
        if (done_i && !w_owner_lock) begin
            w_release = 1'b1;
        end else if (done_i && w_hold_max && w_other_req) begin
            w_release = 1'b1;
        end else if (!w_owner_req) begin
            w_release = 1'b1;
        end else if (!done_i && w_to_hit) begin
            w_release = 1'b1;
            w_timeout = 1'b1;
        end else begin
            w_release = 1'b0;
        end
    end

    // Arbitration FSM with registered grant outputs and hold/timeout counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
            r_to      <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RELEASE: begin
                    r_hold <= '0;
                    r_to   <= '0;
                    if (w_pick_valid) begin
                        r_state <= ST_OWN;
                        r_grant <= w_pick_grant;
                        r_id    <= w_pick_idx;
                        r_valid <= 1'b1;
                        r_ptr   <= IW'(next_idx(32'(w_pick_idx), 32'(N_MST)));
                    end else begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_state   <= ST_RELEASE;
                        r_grant   <= '0;
                        r_valid   <= 1'b0;
                        r_timeout <= w_timeout;
                        r_hold    <= '0;
                        r_to      <= '0;
                    end else begin
                        r_state <= ST_OWN;
                        r_hold  <= w_hold_max ? r_hold : r_hold + HW'(1);
                        r_to    <= done_i ? '0 : r_to + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_hold  <= '0;
                    r_to    <= '0;
                end
            endcase
        end
    end

    assign grant_o     = r_grant;
    assign grant_id_o  = r_id;
    assign gnt_valid_o = r_valid;
    assign timeout_o   = r_timeout;

    // The instruction-fetch master alone never stalls the core.
    assign hold_flag_o = (r_valid && (r_id != IW'(M_INST))) || (|(req_i & ~INST_MASK));

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: behavioural owner/pointer model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rib_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 16;
    localparam int TO   = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       gnt_valid;
    logic       hold_flag;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rib_arbiter #(.N_MST(N), .MAX_HOLD(MAXH), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .lock_i      (lock),
        .done_i      (done),
        .grant_o     (grant),
        .grant_id_o  (grant_id),
        .gnt_valid_o (gnt_valid),
        .hold_flag_o (hold_flag),
        .timeout_o   (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, where round-robin resumes, and how
    // long the owner has held / waited. No owner means the next edge arbitrates.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_wait;
    bit m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_held  <= 0;
            m_wait  <= 0;
            m_to    <= 1'b0;
        end else begin
            int w;
            bit keep;
            bit others;
            w      = -1;
            keep   = 1'b1;
            others = 1'b0;
            m_to <= 1'b0;
            if (m_owner < 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                if (w >= 0) begin
                    m_owner <= w;
                    m_ptr   <= (w + 1) % N;
                    m_held  <= 0;
                    m_wait  <= 0;
                end
            end else begin
                others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
                if (done && !lock[m_owner]) keep = 1'b0;
                else if (done && m_held >= MAXH && others) keep = 1'b0;
                else if (!req[m_owner]) keep = 1'b0;
                else if (!done && m_wait + 1 >= TO) begin
                    keep = 1'b0;
                    m_to <= 1'b1;
                end
                if (keep) begin
                    m_held <= (m_held < MAXH) ? m_held + 1 : MAXH;
                    m_wait <= done ? 0 : m_wait + 1;
                end else begin
                    m_owner <= -1;
                end
            end
        end
    end

    // Compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
        int eg;
        int ehf;
        eg  = (m_owner >= 0) ? (1 << m_owner) : 0;
        ehf = ((m_owner >= 0 && m_owner != 1) || ((req & 4'b1101) != 4'b0000)) ? 1 : 0;
        check("grant_o", int'(grant), eg);
        check("gnt_valid_o", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
        check("timeout_o", int'(timeout), int'(m_to));
        check("hold_flag_o", int'(hold_flag), ehf);
        if (m_owner >= 0) check("grant_id_o", int'(grant_id), m_owner);
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic d);
        req  = r;
        lock = l;
        done = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int  order[$];
        int  exp_a[5];
        bit  prev_v;
        int  t0, t2, tg, tt, tr;
        exp_a = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        done  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_grant", int'(grant), 0);
        check("reset_valid", int'(gnt_valid), 0);
        check("reset_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        check("idle_no_grant", int'(gnt_valid), 0);

        // Plain round robin with turnover cycles.
        prev_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1111, 4'b0000, 1'b1);
            if (gnt_valid && !prev_v) order.push_back(int'(grant_id));
            prev_v = gnt_valid;
        end
        check("A_grant_count", order.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("A_order", (k < order.size()) ? order[k] : 99, exp_a[k]);
        end
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Locked owner hands over after the hold limit.
        t0 = -1;
        t2 = -1;
        for (int i = 0; i < 24; i++) begin
            cyc((i >= 3) ? 4'b0101 : 4'b0001, 4'b0001, 1'b1);
            if (gnt_valid && grant_id == 2'd0 && t0 < 0) t0 = i;
            if (gnt_valid && grant_id == 2'd2 && t2 < 0) t2 = i;
        end
        check("B_first_grant", t0, 0);
        check("B_hold_handover", t2 - t0, 18);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Owner never completes: timeout, turnover, regrant.
        tg = -1;
        tt = -1;
        tr = -1;
        for (int i = 0; i < 300 && tr < 0; i++) begin
            cyc(4'b0100, 4'b0000, 1'b0);
            if (tg < 0 && gnt_valid) tg = i;
            if (tt < 0 && timeout) begin
                tt = i;
                check("C_grant_dropped", int'(grant), 0);
            end
            if (tt >= 0 && i > tt && gnt_valid && tr < 0) begin
                tr = i;
                check("C_regrant_id", int'(grant_id), 2);
            end
        end
        check("C_timeout_after", tt - tg, 255);
        check("C_regrant_delay", tr - tt, 1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Instruction fetch alone does not stall; another master does at once.
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0010, 4'b0000, 1'b0);
            check("D_hold_flag_inst", int'(hold_flag), 0);
        end
        check("D_inst_owner", int'(grant), 2);
        req = 4'b1010;
        #1;
        check("D_hold_flag_same_cycle", int'(hold_flag), 1);
        cyc(4'b1010, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Reset during ownership drops the grant immediately.
        cyc(4'b1000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0);
        check("E_owner3", int'(grant), 8);
        #1;
        rst_n = 1'b0;
        #1;
        check("E_async_grant", int'(grant), 0);
        check("E_async_valid", int'(gnt_valid), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(4'b1000, 4'b0000, 1'b0);
        check("E_regrant", int'(grant), 8);
        check("E_regrant_id", int'(grant_id), 3);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Owner drops its request without completing.
        cyc(4'b0101, 4'b0000, 1'b0);
        check("F_grant0", int'(grant), 1);
        cyc(4'b0100, 4'b0000, 1'b0);
        check("F_release", int'(gnt_valid), 0);
        cyc(4'b0100, 4'b0000, 1'b0);
        check("F_grant2", int'(grant), 4);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
